rifl_rx_lane_bonder: RTL and testbench

Parametrised receive-side channel bonder that merges `N_CHANNEL` per-lane AXI4-Stream outputs of `rifl_rx` into one `N_CHANNEL*PAYLOAD_WIDTH` user stream, in the `tx_frame_clk` domain. Each lane has its own FIFO to absorb inter-lane skew. The block adds what the current bonder lacks:
- runtime lane masking (degraded mode), with mask changes only at packet boundaries;
- short final beats that end at the first lane carrying `tlast`;
- a bounded skew monitor with sticky error and automatic flush;
- a delivered-beat counter.

---
 rtl/rifl_bond_pkg.sv | 27 ++
 rtl/rifl_lane_fifo.sv | 54 +++++
 rtl/rifl_rx_lane_bonder.sv | 149 ++++++++++++++
 tb/tb_rifl_rx_lane_bonder.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rifl_bond_pkg.sv
// Shared constants, width helpers and the lane-head record for the RIFL receive lane bonder.
// Widths in the DEF_* set describe the default build; the helpers size the parametrised one.
package rifl_bond_pkg;

    localparam int DEF_N_CHANNEL     = 4;
    localparam int DEF_PAYLOAD_WIDTH = 240;
    localparam int DEF_FIFO_DEPTH    = 8;
    localparam int DEF_SKEW_LIMIT    = 16;

    localparam int PTR_W  = $clog2(DEF_FIFO_DEPTH);
    localparam int SKEW_W = $clog2(DEF_SKEW_LIMIT + 1);

    typedef struct packed {
        logic [DEF_PAYLOAD_WIDTH-1:0]   data;
        logic [DEF_PAYLOAD_WIDTH/8-1:0] keep;
        logic                           last;
    } lane_head_t;

    function automatic int ptr_width(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    function automatic int skew_width(input int limit);
        return $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/rifl_lane_fifo.sv
// Per-lane synchronous FIFO with synchronous flush; head_o shows the oldest entry (no bypass).
// Pointers carry one extra wrap bit so full and empty are distinguishable at DEPTH entries.
module rifl_lane_fifo
    import rifl_bond_pkg::*;
#(
    parameter int  DEPTH = DEF_FIFO_DEPTH,
    parameter type T     = lane_head_t
) (
    input  logic clk,
    input  logic rst_n,
    input  logic flush_i,
    input  logic wr_en_i,
    input  T     wr_data_i,
    input  logic rd_en_i,
    output T     head_o,
    output logic full_o,
    output logic empty_o
);

    localparam int AW = ptr_width(DEPTH);

    T               mem [DEPTH];
    logic [AW:0]    wr_ptr_q;
    logic [AW:0]    rd_ptr_q;
    logic           do_wr;
    logic           do_rd;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head_o  = mem[rd_ptr_q[AW-1:0]];

    // A flush cycle drops the incoming word as well as the stored ones.
    assign do_wr = wr_en_i && (!full_o || rd_en_i) && !flush_i;
    assign do_rd = rd_en_i && !empty_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (do_rd) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end

    // NOTE: storage is not reset; only the pointers define validity, so the RAM stays a plain array.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end

endmodule

// File: rtl/rifl_rx_lane_bonder.sv
// Bonds N_CHANNEL per-lane rifl_rx streams into one wide stream with lane masking,
// short final beats, a skew watchdog that flushes the lane FIFOs, and a delivered-beat counter.
module rifl_rx_lane_bonder
    import rifl_bond_pkg::*;
#(
    parameter int N_CHANNEL     = DEF_N_CHANNEL,
    parameter int PAYLOAD_WIDTH = DEF_PAYLOAD_WIDTH,
    parameter int FIFO_DEPTH    = DEF_FIFO_DEPTH,
    parameter int SKEW_LIMIT    = DEF_SKEW_LIMIT
) (
    input  logic                                  tx_frame_clk,
    input  logic                                  tx_frame_rst_n,
    input  logic [PAYLOAD_WIDTH-1:0]              s_axis_tdata [N_CHANNEL],
    input  logic [PAYLOAD_WIDTH/8-1:0]            s_axis_tkeep [N_CHANNEL],
    input  logic [N_CHANNEL-1:0]                  s_axis_tlast,
    input  logic [N_CHANNEL-1:0]                  s_axis_tvalid,
    output logic [N_CHANNEL-1:0]                  s_axis_tready,
    output logic [N_CHANNEL*PAYLOAD_WIDTH-1:0]    m_axis_tdata,
    output logic [N_CHANNEL*PAYLOAD_WIDTH/8-1:0]  m_axis_tkeep,
    output logic                                  m_axis_tlast,
    output logic                                  m_axis_tvalid,
    input  logic                                  m_axis_tready,
    input  logic [N_CHANNEL-1:0]                  lane_mask,
    output logic [N_CHANNEL-1:0]                  active_mask,
    input  logic                                  clear_error,
    output logic                                  skew_error,
    output logic [31:0]                           beat_cnt
);

    localparam int KEEP_W = PAYLOAD_WIDTH / 8;
    localparam int SW     = skew_width(SKEW_LIMIT);

    typedef struct packed {
        logic [PAYLOAD_WIDTH-1:0] data;
        logic [KEEP_W-1:0]        keep;
        logic                     last;
    } head_t;

    head_t                             head    [N_CHANNEL];
    head_t                             wr_data [N_CHANNEL];
    logic [N_CHANNEL-1:0]              full, empty, wr_en, rd_en, fifo_flush;
    logic [N_CHANNEL-1:0]              active_mask_q, beat_set;
    logic                              set_last, set_ready, out_free, emit;
    logic                              any_pending, stall, timeout, skew_hit, mask_load;
    logic [N_CHANNEL*PAYLOAD_WIDTH-1:0] bond_data, m_tdata_q;
    logic [N_CHANNEL*KEEP_W-1:0]       bond_keep, m_tkeep_q;
    logic                              m_tlast_q, m_tvalid_q, skew_error_q;
    logic [SW-1:0]                     skew_cnt_q;
    logic [31:0]                       beat_cnt_q;

    for (genvar i = 0; i < N_CHANNEL; i++) begin : g_lane
        assign wr_data[i]       = '{data: s_axis_tdata[i], keep: s_axis_tkeep[i], last: s_axis_tlast[i]};
        // Masked-off lanes always accept and drop their traffic.
        assign s_axis_tready[i] = tx_frame_rst_n && (!active_mask_q[i] || !full[i]);
        assign wr_en[i]         = s_axis_tvalid[i] && active_mask_q[i] && !full[i];
        assign rd_en[i]         = emit && beat_set[i];
        assign fifo_flush[i]    = timeout || !active_mask_q[i];

        rifl_lane_fifo #(
            .DEPTH (FIFO_DEPTH),
            .T     (head_t)
        ) u_fifo (
            .clk       (tx_frame_clk),
            .rst_n     (tx_frame_rst_n),
            .flush_i   (fifo_flush[i]),
            .wr_en_i   (wr_en[i]),
            .wr_data_i (wr_data[i]),
            .rd_en_i   (rd_en[i]),
            .head_o    (head[i]),
            .full_o    (full[i]),
            .empty_o   (empty[i])
        );
    end

    // NOTE: blocking '=' here is deliberate: set_last must update mid-loop so later lanes see it.
    always_comb begin
        beat_set = '0;
        set_last = 1'b0;
        for (int i = 0; i < N_CHANNEL; i++) begin
            if (active_mask_q[i] && !set_last) begin
                beat_set[i] = 1'b1;
                if (!empty[i] && head[i].last) set_last = 1'b1;
            end
        end
    end

    // NOTE: defaults first so every path assigns every bit and no latch is inferred.
    always_comb begin
        bond_data = '0;
        bond_keep = '0;
        for (int i = 0; i < N_CHANNEL; i++) begin
            if (beat_set[i]) begin
                bond_data[i*PAYLOAD_WIDTH +: PAYLOAD_WIDTH] = head[i].data;
                bond_keep[i*KEEP_W +: KEEP_W]               = head[i].keep;
            end
        end
    end

    assign out_free    = !m_tvalid_q || m_axis_tready;
    assign timeout     = (skew_cnt_q == SW'(SKEW_LIMIT));
    assign set_ready   = (|beat_set) && !(|(beat_set & empty));
    assign emit        = set_ready && out_free && !timeout;
    assign any_pending = |(active_mask_q & ~empty);
    assign stall       = any_pending && (|(beat_set & empty)) && out_free;
    // The error flag rises on the same edge the counter reaches the limit; the flush follows one edge later.
    assign skew_hit    = stall && (skew_cnt_q == SW'(SKEW_LIMIT - 1));
    assign mask_load   = (emit && set_last) || ((&empty) && out_free);

    always_ff @(posedge tx_frame_clk or negedge tx_frame_rst_n) begin
        if (!tx_frame_rst_n) begin
            m_tdata_q     <= '0;
            m_tkeep_q     <= '0;
            m_tlast_q     <= 1'b0;
            m_tvalid_q    <= 1'b0;
            active_mask_q <= '1;
            skew_cnt_q    <= '0;
            skew_error_q  <= 1'b0;
            beat_cnt_q    <= '0;
        end else begin
            if (emit) begin
                m_tdata_q  <= bond_data;
                m_tkeep_q  <= bond_keep;
                m_tlast_q  <= set_last;
                m_tvalid_q <= 1'b1;
            end else if (m_axis_tready) begin
                m_tvalid_q <= 1'b0;
            end

            if (mask_load) active_mask_q <= lane_mask;

            if (timeout || emit || !any_pending) skew_cnt_q <= '0;
            else if (stall)                      skew_cnt_q <= skew_cnt_q + SW'(1);

            if (skew_hit)         skew_error_q <= 1'b1;
            else if (clear_error) skew_error_q <= 1'b0;

            if (m_tvalid_q && m_axis_tready) beat_cnt_q <= beat_cnt_q + 32'd1;
        end
    end

    assign m_axis_tdata  = m_tdata_q;
    assign m_axis_tkeep  = m_tkeep_q;
    assign m_axis_tlast  = m_tlast_q;
    assign m_axis_tvalid = m_tvalid_q;
    assign active_mask   = active_mask_q;
    assign skew_error    = skew_error_q;
    assign beat_cnt      = beat_cnt_q;

endmodule

// File: tb/tb_rifl_rx_lane_bonder.sv
// Scoreboard bench for rifl_rx_lane_bonder: tests push expected bonded beats, a negedge monitor
// pops and compares them on every output handshake; feature tasks add their own timing checks.
module tb_rifl_rx_lane_bonder;

    localparam int N     = 4;
    localparam int PW    = 240;
    localparam int KW    = PW / 8;
    localparam int DEPTH = 8;
    localparam int LIMIT = 16;

    typedef struct packed {
        logic [N*PW-1:0] data;
        logic [N*KW-1:0] keep;
        logic            last;
    } beat_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic [PW-1:0]   s_tdata [N];
    logic [KW-1:0]   s_tkeep [N];
    logic [N-1:0]    s_tlast, s_tvalid, s_tready;
    logic [N*PW-1:0] m_tdata;
    logic [N*KW-1:0] m_tkeep;
    logic            m_tlast, m_tvalid, m_tready;
    logic [N-1:0]    lane_mask, active_mask;
    logic            clear_error, skew_error;
    logic [31:0]     beat_cnt;

    int              tests_run = 0;
    int              tests_failed = 0;
    beat_t           exp_q [$];
    logic [PW-1:0]   nxt_data [N];
    logic [KW-1:0]   nxt_keep [N];

    always #5 clk = ~clk;

    rifl_rx_lane_bonder #(
        .N_CHANNEL     (N),
        .PAYLOAD_WIDTH (PW),
        .FIFO_DEPTH    (DEPTH),
        .SKEW_LIMIT    (LIMIT)
    ) dut (
        .tx_frame_clk   (clk),
        .tx_frame_rst_n (rst_n),
        .s_axis_tdata   (s_tdata),
        .s_axis_tkeep   (s_tkeep),
        .s_axis_tlast   (s_tlast),
        .s_axis_tvalid  (s_tvalid),
        .s_axis_tready  (s_tready),
        .m_axis_tdata   (m_tdata),
        .m_axis_tkeep   (m_tkeep),
        .m_axis_tlast   (m_tlast),
        .m_axis_tvalid  (m_tvalid),
        .m_axis_tready  (m_tready),
        .lane_mask      (lane_mask),
        .active_mask    (active_mask),
        .clear_error    (clear_error),
        .skew_error     (skew_error),
        .beat_cnt       (beat_cnt)
    );

    function automatic logic [PW-1:0] rand_payload();
        logic [PW+31:0] v = '0;
        for (int j = 0; j < (PW + 31) / 32; j++) v = {v[PW-1:0], $urandom()};
        return v[PW-1:0];
    endfunction

    function automatic beat_t make_beat(input logic [PW-1:0] d [N], input logic [KW-1:0] k [N],
                                        input logic [N-1:0] set, input logic last);
        beat_t b = '0;
        for (int i = 0; i < N; i++) begin
            if (set[i]) begin
                b.data[i*PW +: PW] = d[i];
                b.keep[i*KW +: KW] = k[i];
            end
        end
        b.last = last;
        return b;
    endfunction

    task automatic gen_lanes(input bit rand_keep);
        for (int i = 0; i < N; i++) begin
            nxt_data[i] = rand_payload();
            nxt_keep[i] = rand_keep ? (KW'($urandom()) | KW'(1)) : '1;
        end
    endtask

    // Starts and ends one time unit after a rising edge; holds each lane valid until accepted.
    task automatic drive_beat(input logic [N-1:0] lanes, input logic [N-1:0] lasts);
        logic [N-1:0] pending = lanes;
        logic [N-1:0] acc;
        int guard = 0;
        for (int i = 0; i < N; i++) begin
            s_tdata[i] = nxt_data[i];
            s_tkeep[i] = nxt_keep[i];
        end
        s_tlast  = lasts;
        s_tvalid = pending;
        while (pending != '0 && guard < 50) begin
            @(negedge clk);
            acc = pending & s_tready;
            @(posedge clk); #1;
            pending  = pending & ~acc;
            s_tvalid = pending;
            guard++;
        end
        if (pending != '0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL drive_timeout lanes_not_accepted=%b required=0000", pending);
            s_tvalid = '0;
        end
    endtask

    task automatic wait_drain();
        int guard = 0;
        while ((exp_q.size() != 0 || m_tvalid) && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL drain_timeout beats_outstanding=%0d required=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Scoreboard monitor: every handshake must match the oldest expected beat.
    initial begin
        beat_t e;
        int bad;
        forever begin
            @(negedge clk);
            if (rst_n && m_tvalid && m_tready) begin
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL unexpected_beat got last=%b keep=%h, required no beat", m_tlast, m_tkeep);
                end else begin
                    e = exp_q.pop_front();
                    if (m_tdata !== e.data || m_tkeep !== e.keep || m_tlast !== e.last) begin
                        tests_failed++;
                        bad = 0;
                        for (int i = N - 1; i >= 0; i--)
                            if (m_tdata[i*PW +: PW] !== e.data[i*PW +: PW] ||
                                m_tkeep[i*KW +: KW] !== e.keep[i*KW +: KW]) bad = i;
                        $display("FAIL beat_compare lane %0d data=%h exp=%h keep=%h exp=%h last=%b exp=%b",
                                 bad, m_tdata[bad*PW +: PW], e.data[bad*PW +: PW],
                                 m_tkeep[bad*KW +: KW], e.keep[bad*KW +: KW], m_tlast, e.last);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic test_reset();
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (s_tready !== 4'b0000 || m_tvalid !== 1'b0 || m_tlast !== 1'b0 || m_tkeep !== '0 ||
            m_tdata !== '0 || active_mask !== 4'b1111 || skew_error !== 1'b0 || beat_cnt !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_state tready=%b valid=%b last=%b amask=%b err=%b cnt=%0d required 0000 0 0 1111 0 0",
                     s_tready, m_tvalid, m_tlast, active_mask, skew_error, beat_cnt);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if (s_tready !== 4'b1111) begin
            tests_failed++;
            $display("FAIL ready_after_reset got=%b required=1111", s_tready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_aligned();
        for (int b = 0; b < 3; b++) begin
            gen_lanes(1'b0);
            exp_q.push_back(make_beat(nxt_data, nxt_keep, 4'b1111, b == 2));
            drive_beat(4'b1111, (b == 2) ? 4'b1000 : 4'b0000);
        end
        wait_drain();
        @(negedge clk);
        tests_run++;
        if (beat_cnt !== 32'd3) begin
            tests_failed++;
            $display("FAIL aligned_beat_cnt got=%0d required=3", beat_cnt);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_short_beat();
        logic [PW-1:0] mix_data [N];
        logic [KW-1:0] mix_keep [N];
        gen_lanes(1'b1);
        exp_q.push_back(make_beat(nxt_data, nxt_keep, 4'b0011, 1'b1));
        mix_data = nxt_data;
        mix_keep = nxt_keep;
        drive_beat(4'b1111, 4'b1010);
        gen_lanes(1'b1);
        mix_data[0] = nxt_data[0];
        mix_data[1] = nxt_data[1];
        mix_keep[0] = nxt_keep[0];
        mix_keep[1] = nxt_keep[1];
        exp_q.push_back(make_beat(mix_data, mix_keep, 4'b1111, 1'b1));
        drive_beat(4'b0011, 4'b0000);
        wait_drain();
    endtask

    task automatic test_skew_within();
        gen_lanes(1'b0);
        exp_q.push_back(make_beat(nxt_data, nxt_keep, 4'b1111, 1'b1));
        for (int i = 0; i < N; i++) begin
            s_tdata[i] = nxt_data[i];
            s_tkeep[i] = nxt_keep[i];
        end
        s_tlast  = 4'b1000;
        s_tvalid = 4'b1011;
        @(posedge clk); #1;
        s_tvalid = '0;
        repeat (4) @(posedge clk);
        #1;
        s_tvalid = 4'b0100;
        @(posedge clk); #1;
        s_tvalid = '0;
        @(negedge clk);
        tests_run++;
        if (m_tvalid !== 1'b0) begin
            tests_failed++;
            $display("FAIL skew_latency_early valid=%b required=0", m_tvalid);
        end
        @(negedge clk);
        tests_run++;
        if (m_tvalid !== 1'b1 || skew_error !== 1'b0) begin
            tests_failed++;
            $display("FAIL skew_latency valid=%b err=%b required valid=1 err=0", m_tvalid, skew_error);
        end
        @(posedge clk); #1;
        wait_drain();
    endtask

    task automatic test_skew_timeout();
        gen_lanes(1'b0);
        for (int i = 0; i < N; i++) begin
            s_tdata[i] = nxt_data[i];
            s_tkeep[i] = nxt_keep[i];
        end
        s_tlast  = 4'b0000;
        s_tvalid = 4'b0111;
        @(posedge clk); #1;
        s_tvalid = '0;
        repeat (LIMIT - 1) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (skew_error !== 1'b0) begin
            tests_failed++;
            $display("FAIL skew_error_early got=%b required=0", skew_error);
        end
        @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (skew_error !== 1'b1) begin
            tests_failed++;
            $display("FAIL skew_error_set got=%b required=1", skew_error);
        end
        @(posedge clk); #1;
        clear_error = 1'b1;
        @(posedge clk); #1;
        clear_error = 1'b0;
        @(negedge clk);
        tests_run++;
        if (skew_error !== 1'b0) begin
            tests_failed++;
            $display("FAIL skew_error_clear got=%b required=0", skew_error);
        end
        @(posedge clk); #1;
        // Stale heads must be gone: a fresh packet comes out untouched.
        gen_lanes(1'b0);
        exp_q.push_back(make_beat(nxt_data, nxt_keep, 4'b1111, 1'b1));
        drive_beat(4'b1111, 4'b1000);
        wait_drain();
    endtask

    task automatic test_degraded();
        bit lane2_blocked = 1'b0;
        m_tready = 1'b0;
        gen_lanes(1'b0);
        exp_q.push_back(make_beat(nxt_data, nxt_keep, 4'b1111, 1'b0));
        drive_beat(4'b1111, 4'b0000);
        gen_lanes(1'b0);
        exp_q.push_back(make_beat(nxt_data, nxt_keep, 4'b1111, 1'b1));
        drive_beat(4'b1111, 4'b1000);
        repeat (2) @(posedge clk);
        #1;
        lane_mask = 4'b1011;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (active_mask !== 4'b1111) begin
            tests_failed++;
            $display("FAIL mask_mid_packet got=%b required=1111", active_mask);
        end
        @(posedge clk); #1;
        m_tready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (active_mask !== 4'b1011) begin
            tests_failed++;
            $display("FAIL mask_after_tlast got=%b required=1011", active_mask);
        end
        @(posedge clk); #1;
        s_tdata[2] = rand_payload();
        s_tlast    = '0;
        s_tvalid   = 4'b0100;
        for (int c = 0; c < 2 * DEPTH; c++) begin
            @(negedge clk);
            if (s_tready[2] !== 1'b1) lane2_blocked = 1'b1;
            @(posedge clk); #1;
        end
        s_tvalid = '0;
        tests_run++;
        if (lane2_blocked) begin
            tests_failed++;
            $display("FAIL disabled_lane_ready got=0 required=1");
        end
        gen_lanes(1'b0);
        exp_q.push_back(make_beat(nxt_data, nxt_keep, 4'b1011, 1'b1));
        drive_beat(4'b1111, 4'b1000);
        wait_drain();
        lane_mask = 4'b1111;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (active_mask !== 4'b1111) begin
            tests_failed++;
            $display("FAIL mask_idle_reload got=%b required=1111", active_mask);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        m_tready = 1'b0;
        for (int b = 0; b < DEPTH + 1; b++) begin
            gen_lanes(1'b1);
            exp_q.push_back(make_beat(nxt_data, nxt_keep, 4'b1111, 1'b0));
            drive_beat(4'b1111, 4'b0000);
        end
        @(negedge clk);
        tests_run++;
        if (s_tready !== 4'b0000) begin
            tests_failed++;
            $display("FAIL backpressure_ready got=%b required=0000", s_tready);
        end
        for (int h = 0; h < 2; h++) begin
            tests_run++;
            if (m_tvalid !== 1'b1 || m_tdata !== exp_q[0].data || m_tkeep !== exp_q[0].keep) begin
                tests_failed++;
                $display("FAIL held_beat_stable valid=%b keep=%h required valid=1 keep=%h",
                         m_tvalid, m_tkeep, exp_q[0].keep);
            end
            @(posedge clk);
            @(negedge clk);
        end
        @(posedge clk); #1;
        m_tready = 1'b1;
        for (int b = 0; b < 3; b++) begin
            gen_lanes(1'b0);
            exp_q.push_back(make_beat(nxt_data, nxt_keep, 4'b1111, b == 2));
            drive_beat(4'b1111, (b == 2) ? 4'b1000 : 4'b0000);
        end
        wait_drain();
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            s_tdata[i] = '0;
            s_tkeep[i] = '0;
        end
        s_tlast     = '0;
        s_tvalid    = '0;
        m_tready    = 1'b1;
        lane_mask   = 4'b1111;
        clear_error = 1'b0;

        test_reset();
        test_aligned();
        test_short_beat();
        test_skew_within();
        test_skew_timeout();
        test_degraded();
        test_backpressure();

        @(negedge clk);
        tests_run++;
        if (beat_cnt !== 32'd22) begin
            tests_failed++;
            $display("FAIL total_beat_cnt got=%0d required=22", beat_cnt);
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
